// File: rtl/ram_cmd_pkg.sv
// Shared definitions for the command-RAM arbiter: command width, opcodes, FSM states.
package ram_cmd_pkg;

   localparam int unsigned CMD_W = 10;

   localparam logic [1:0] OP_WADDR = 2'b00;
   localparam logic [1:0] OP_WDATA = 2'b01;
   localparam logic [1:0] OP_RADDR = 2'b10;
   localparam logic [1:0] OP_READ  = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCKED = 2'd1,
      RD_W1  = 2'd2,
      RD_W2  = 2'd3
   } state_t;

endpackage

// File: rtl/ram_cmd_arbiter_if.sv
// Requester and RAM-side bus of the command arbiter; slave is the arbiter's view.
interface ram_cmd_arbiter_if #(
   parameter int unsigned ADDER_SIZE = 8
);
   import ram_cmd_pkg::*;

   logic [CMD_W-1:0]      req0_din;
   logic                  req0_valid;
   logic                  req0_ready;
   logic [ADDER_SIZE-1:0] req0_rdata;
   logic                  req0_rvalid;

   logic [CMD_W-1:0]      req1_din;
   logic                  req1_valid;
   logic                  req1_ready;
   logic [ADDER_SIZE-1:0] req1_rdata;
   logic                  req1_rvalid;

   logic [CMD_W-1:0]      ram_din;
   logic                  ram_rx_valid;
   logic [ADDER_SIZE-1:0] ram_dout;
   logic                  ram_tx_valid;

   modport master (
      output req0_din, req0_valid, req1_din, req1_valid, ram_dout, ram_tx_valid,
      input  req0_ready, req0_rdata, req0_rvalid,
      input  req1_ready, req1_rdata, req1_rvalid,
      input  ram_din, ram_rx_valid
   );

   modport slave (
      input  req0_din, req0_valid, req1_din, req1_valid, ram_dout, ram_tx_valid,
      output req0_ready, req0_rdata, req0_rvalid,
      output req1_ready, req1_rdata, req1_rvalid,
      output ram_din, ram_rx_valid
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin select; a held lock forces the selection to the lock owner.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last,
   input  logic       lock_en,
   input  logic       lock_owner,
   output logic       sel,
   output logic       gnt
);

   always_comb begin
      sel = 1'b0;
      gnt = 1'b0;
      if (lock_en) begin
         sel = lock_owner;
         gnt = valid[lock_owner];
      end else begin
         gnt = |valid;
         // On a tie the requester that did not win last time is chosen
         if (&valid) sel = ~last;
         else        sel = valid[1];
      end
   end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Arbitrates two command streams onto one single-port command RAM, locking the grant
// from an address command to its data/read command and routing read data back.
module ram_cmd_arbiter
   import ram_cmd_pkg::*;
#(
   parameter int unsigned ADDER_SIZE   = 8,
   parameter int unsigned LOCK_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   ram_cmd_arbiter_if.slave bus,
   output logic            lock_timeout
);

   localparam int unsigned TW = ($clog2(LOCK_TIMEOUT) > 0) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_MAX = TW'(LOCK_TIMEOUT - 1);

   state_t           state;
   logic             last;
   logic             owner;
   logic             reader;
   logic [TW-1:0]    timer;

   logic             sel;
   logic             gnt;
   logic             open;
   logic             accept;
   logic [CMD_W-1:0] cmd;
   logic [1:0]       op;

   rr_arb2 u_rr_arb2 (
      .valid      ({bus.req1_valid, bus.req0_valid}),
      .last       (last),
      .lock_en    (state == LOCKED),
      .lock_owner (owner),
      .sel        (sel),
      .gnt        (gnt)
   );

   assign open   = (state == IDLE) || (state == LOCKED);
   assign accept = open && gnt;
   assign cmd    = sel ? bus.req1_din : bus.req0_din;
   assign op     = cmd[CMD_W-1:CMD_W-2];

   assign bus.req0_ready = accept && !sel;
   assign bus.req1_ready = accept && sel;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         last             <= 1'b1;
         owner            <= 1'b0;
         reader           <= 1'b0;
         timer            <= '0;
         lock_timeout     <= 1'b0;
         bus.ram_din      <= '0;
         bus.ram_rx_valid <= 1'b0;
         bus.req0_rdata   <= '0;
         bus.req0_rvalid  <= 1'b0;
         bus.req1_rdata   <= '0;
         bus.req1_rvalid  <= 1'b0;
      end else begin
         bus.ram_rx_valid <= accept;
         if (accept) bus.ram_din <= cmd;
         bus.req0_rvalid <= 1'b0;
         bus.req1_rvalid <= 1'b0;
         lock_timeout    <= 1'b0;

         case (state)
            IDLE: begin
               if (accept) begin
                  if (bus.req0_valid && bus.req1_valid) last <= sel;
                  case (op)
                     OP_WADDR, OP_RADDR: begin
                        state <= LOCKED;
                        owner <= sel;
                        timer <= '0;
                     end
                     OP_READ: begin
                        state  <= RD_W1;
                        reader <= sel;
                     end
                     default: state <= IDLE;
                  endcase
               end
            end

            LOCKED: begin
               // The completion opcode is not matched against the address opcode:
               // any data/read from the owner ends the lock and the RAM executes it.
               if (accept) begin
                  case (op)
                     OP_WDATA: state <= IDLE;
                     OP_READ: begin
                        state  <= RD_W1;
                        reader <= owner;
                     end
                     default: timer <= '0;
                  endcase
               end else if (timer == TO_MAX) begin
                  state        <= IDLE;
                  lock_timeout <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            RD_W1: state <= RD_W2;

            RD_W2: begin
               if (reader) begin
                  bus.req1_rdata  <= bus.ram_dout;
                  bus.req1_rvalid <= 1'b1;
               end else begin
                  bus.req0_rdata  <= bus.ram_dout;
                  bus.req0_rvalid <= 1'b1;
               end
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter with a behavioural command RAM and scoreboards
// for RAM commands and read returns.
module tb_ram_cmd_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic lock_timeout;

   always #5 clk = ~clk;

   ram_cmd_arbiter_if #(.ADDER_SIZE(8)) bus ();

   ram_cmd_arbiter #(.ADDER_SIZE(8), .LOCK_TIMEOUT(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .lock_timeout (lock_timeout)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [9:0] cmd_q[$];
   logic [8:0] rd_q[$];   // {requester, data}

   // Behavioural command RAM: shared address registers, sticky read-valid
   logic [7:0] mem [256] = '{default: 8'h00};
   logic [7:0] waddr_m = '0;
   logic [7:0] raddr_m = '0;
   logic [7:0] dout_m  = '0;
   logic       tx_m    = 1'b0;
   assign bus.ram_dout     = dout_m;
   assign bus.ram_tx_valid = tx_m;

   always @(posedge clk) begin
      if (bus.ram_rx_valid === 1'b1) begin
         case (bus.ram_din[9:8])
            2'b00:   waddr_m <= bus.ram_din[7:0];
            2'b01:   mem[waddr_m] <= bus.ram_din[7:0];
            2'b10:   raddr_m <= bus.ram_din[7:0];
            default: begin
               dout_m <= mem[raddr_m];
               tx_m   <= 1'b1;
            end
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.ram_rx_valid === 1'b1) begin
         check("cmd_pending", 32'(cmd_q.size() != 0), 1);
         if (cmd_q.size() != 0) check("ram_din", 32'(bus.ram_din), 32'(cmd_q.pop_front()));
      end
      if (bus.req0_rvalid === 1'b1 || bus.req1_rvalid === 1'b1) begin
         logic [8:0] e;
         check("rd_pending", 32'(rd_q.size() != 0), 1);
         if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            check("rd_who", {30'b0, bus.req1_rvalid, bus.req0_rvalid}, e[8] ? 32'd2 : 32'd1);
            check("rdata", 32'(e[8] ? bus.req1_rdata : bus.req0_rdata), 32'(e[7:0]));
            check("tx_valid_at_capture", 32'(bus.ram_tx_valid), 1);
         end
      end
   end

   task automatic drive(input int r, input logic [9:0] w, input logic v);
      if (r == 0) begin bus.req0_din = w; bus.req0_valid = v; end
      else        begin bus.req1_din = w; bus.req1_valid = v; end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(input int r, input string tag);
      logic got;
      logic rdy;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         rdy = (r == 0) ? bus.req0_ready : bus.req1_ready;
         tick();
         got = (rdy === 1'b1);
      end
      check(tag, 32'(got), 1);
   endtask

   task automatic send(input int r, input logic [9:0] w);
      drive(r, w, 1'b1);
      cmd_q.push_back(w);
      wait_accept(r, "accept");
      drive(r, w, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      drive(0, '0, 1'b0);
      drive(1, '0, 1'b0);
      tick();
      tick();
      @(negedge clk);
      check("rst_ram_rx_valid", 32'(bus.ram_rx_valid), 0);
      check("rst_ram_din", 32'(bus.ram_din), 0);
      check("rst_rvalid", {30'b0, bus.req1_rvalid, bus.req0_rvalid}, 0);
      check("rst_rdata", {16'b0, bus.req1_rdata, bus.req0_rdata}, 0);
      check("rst_lock_timeout", 32'(lock_timeout), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Write then read through req0, with req1 waiting during the read
      send(0, 10'h005);
      send(0, 10'h1A5);
      send(0, 10'h205);
      rd_q.push_back({1'b0, 8'hA5});
      send(0, 10'h300);
      drive(1, 10'h1A5, 1'b1);
      cmd_q.push_back(10'h1A5);
      @(negedge clk);
      check("rd_w1_ready1", 32'(bus.req1_ready), 0);
      check("rd_w1_rvalid0", 32'(bus.req0_rvalid), 0);
      tick();
      @(negedge clk);
      check("rd_w2_ready1", 32'(bus.req1_ready), 0);
      check("rd_w2_rvalid0", 32'(bus.req0_rvalid), 0);
      tick();
      @(negedge clk);
      check("rvalid0_pulse", 32'(bus.req0_rvalid), 1);
      check("rdata0", 32'(bus.req0_rdata), 32'h0A5);
      check("ready1_with_rvalid", 32'(bus.req1_ready), 1);
      tick();
      drive(1, 10'h1A5, 1'b0);
      @(negedge clk);
      check("rvalid0_one_cycle", 32'(bus.req0_rvalid), 0);
      tick();

      // Lock blocks interleave
      send(0, 10'h010);
      drive(1, 10'h020, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("lock_ready1", 32'(bus.req1_ready), 0);
         tick();
      end
      send(0, 10'h1FF);
      cmd_q.push_back(10'h020);
      wait_accept(1, "accept_after_unlock");
      drive(1, 10'h020, 1'b0);
      send(1, 10'h15A);
      send(1, 10'h220);
      rd_q.push_back({1'b1, 8'h5A});
      send(1, 10'h300);
      repeat (3) tick();
      send(0, 10'h210);
      rd_q.push_back({1'b0, 8'hFF});
      send(0, 10'h300);
      repeat (3) tick();

      // Round-robin on continuous ties
      drive(0, 10'h111, 1'b1);
      drive(1, 10'h122, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cmd_q.push_back((i % 2 == 0) ? 10'h111 : 10'h122);
         @(negedge clk);
         check("rr_ready0", 32'(bus.req0_ready), 32'(i % 2 == 0));
         check("rr_ready1", 32'(bus.req1_ready), 32'(i % 2 == 1));
         if (i > 0) check("rr_strobe", 32'(bus.ram_rx_valid), 1);
         tick();
      end
      drive(0, 10'h111, 1'b0);
      drive(1, 10'h122, 1'b0);
      @(negedge clk);
      check("rr_last_strobe", 32'(bus.ram_rx_valid), 1);
      tick();
      @(negedge clk);
      check("rr_strobe_end", 32'(bus.ram_rx_valid), 0);
      tick();

      // Lock timeout, req0 waiting
      send(1, 10'h230);
      drive(0, 10'h1C3, 1'b1);
      cmd_q.push_back(10'h1C3);
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         check("to_pulse_early", 32'(lock_timeout), 0);
         check("to_ready0_blocked", 32'(bus.req0_ready), 0);
         tick();
      end
      @(negedge clk);
      check("to_pulse", 32'(lock_timeout), 1);
      check("to_ready0_granted", 32'(bus.req0_ready), 1);
      tick();
      drive(0, 10'h1C3, 1'b0);
      @(negedge clk);
      check("to_pulse_once", 32'(lock_timeout), 0);
      tick();

      // One tie leaves last=0 ahead of the reset test
      drive(0, 10'h1AA, 1'b1);
      drive(1, 10'h1BB, 1'b1);
      cmd_q.push_back(10'h1AA);
      @(negedge clk);
      check("tie_pre_reset_ready0", 32'(bus.req0_ready), 1);
      tick();
      drive(0, 10'h1AA, 1'b0);
      drive(1, 10'h1BB, 1'b0);
      tick();

      // Reset during RD_W1
      send(0, 10'h300);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_ram_rx_valid", 32'(bus.ram_rx_valid), 0);
      check("mid_rst_ram_din", 32'(bus.ram_din), 0);
      check("mid_rst_rdata", {16'b0, bus.req1_rdata, bus.req0_rdata}, 0);
      check("mid_rst_rvalid", {30'b0, bus.req1_rvalid, bus.req0_rvalid}, 0);
      check("mid_rst_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 0);
      check("mid_rst_lock_timeout", 32'(lock_timeout), 0);
      tick();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("mid_rst_no_rvalid", 32'(bus.req0_rvalid), 0);
         tick();
      end
      drive(0, 10'h1AB, 1'b1);
      drive(1, 10'h1CD, 1'b1);
      cmd_q.push_back(10'h1AB);
      @(negedge clk);
      check("post_rst_tie_ready0", 32'(bus.req0_ready), 1);
      check("post_rst_tie_ready1", 32'(bus.req1_ready), 0);
      tick();
      drive(0, 10'h1AB, 1'b0);
      drive(1, 10'h1CD, 1'b0);
      repeat (4) tick();

      check("cmd_q_drained", 32'(cmd_q.size()), 0);
      check("rd_q_drained", 32'(rd_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
